voice_sample_bank: RTL and testbench

- Upstream source stage for the 8-voice mixer.
- Holds one phase accumulator per voice and time-multiplexes a single sine ROM across all 8 voices.
- On each sample request it produces a fresh 128-bit packed bus of eight signed 16-bit voice samples. The mixer sums this bus directly.
- Request/ready handshake: the codec-rate request comes in, and a one-cycle ready pulse goes out once the whole bus is valid.

---
 rtl/piano_pkg.sv | 28 ++
 rtl/voice_sample_bank_if.sv | 21 ++
 rtl/sine_rom.sv | 25 ++
 rtl/voice_sample_bank.sv | 86 ++++++++
 tb/tb_voice_sample_bank.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared widths, FSM encoding and phase-to-address helper for the voice source stage.
package piano_pkg;
    localparam int NUM_VOICES = 8;
    localparam int PHASE_W    = 22;
    localparam int ADDR_W     = 10;
    localparam int SAMPLE_W   = 16;
    localparam int BUS_W      = NUM_VOICES * SAMPLE_W;
    localparam int VOICE_W    = $clog2(NUM_VOICES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ADDR  = ST_ADDR,
        LATCH = ST_LATCH,
        DONE  = ST_DONE
    } state_t;

    typedef logic [PHASE_W-1:0]         phase_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic logic [ADDR_W-1:0] phase_to_addr(input phase_t p);
        return p[PHASE_W-1 -: ADDR_W];
    endfunction
endpackage

// File: rtl/voice_sample_bank_if.sv
// Request/ready bus between the codec-rate requester and the voice sample bank.
interface voice_sample_bank_if;
    import piano_pkg::*;

    logic                          generate_next;
    logic [NUM_VOICES-1:0]         note_active;
    logic [NUM_VOICES*PHASE_W-1:0] note_steps;
    logic [BUS_W-1:0]              samples;
    logic                          samples_ready;
    logic                          overrun;

    modport master (
        output generate_next, note_active, note_steps,
        input  samples, samples_ready, overrun
    );

    modport slave (
        input  generate_next, note_active, note_steps,
        output samples, samples_ready, overrun
    );
endinterface

// File: rtl/sine_rom.sv
// Full-cycle sine table, entry k = round(32767*sin(2*pi*k/2^ADDR_W)).
// Synchronous read, 1-cycle latency; no backpressure.
module sine_rom
    import piano_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output sample_t           data
);
    localparam int DEPTH = 2 ** ADDR_W;

    sample_t rom_tab [DEPTH];

    // Table contents are elaboration-time constants, rounded half away from zero.
    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        localparam real ANG = 2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH);
        localparam real AMP = 32767.0 * $sin(ANG);
        localparam int  VAL = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
        assign rom_tab[k] = SAMPLE_W'(VAL);
    end

    always_ff @(posedge clk) begin
        data <= rom_tab[addr];
    end
endmodule

// File: rtl/voice_sample_bank.sv
// Eight phase accumulators sharing one sine ROM; emits a 128-bit sample bus per request.
// Latency: request edge t0 -> samples_ready pulse at t0+17. Requests while busy are dropped (sticky overrun).
module voice_sample_bank
    import piano_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    voice_sample_bank_if.slave  bus
);
    localparam logic [VOICE_W-1:0] LAST_V = VOICE_W'(NUM_VOICES - 1);

    state_t                state;
    logic [VOICE_W-1:0]    v;
    logic [NUM_VOICES-1:0] active_q;
    phase_t                steps_q [NUM_VOICES];
    phase_t                phase   [NUM_VOICES];
    sample_t               shadow  [NUM_VOICES];

    phase_t                phase_sum;
    logic [ADDR_W-1:0]     rom_addr;
    sample_t               rom_data;

    always_comb begin
        phase_sum = phase[v] + steps_q[v];
        rom_addr  = phase_to_addr(phase_sum);
    end

    sine_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            v                 <= '0;
            active_q          <= '0;
            bus.samples       <= '0;
            bus.samples_ready <= 1'b0;
            bus.overrun       <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                steps_q[i] <= '0;
                phase[i]   <= '0;
                shadow[i]  <= '0;
            end
        end else begin
            bus.samples_ready <= 1'b0;
            if (bus.generate_next && state != IDLE)
                bus.overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.generate_next) begin
                        active_q <= bus.note_active;
                        for (int i = 0; i < NUM_VOICES; i++)
                            steps_q[i] <= bus.note_steps[i*PHASE_W +: PHASE_W];
                        v     <= '0;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    // Inactive voices restart at the zero crossing when re-triggered.
                    phase[v] <= active_q[v] ? phase_sum : '0;
                    state    <= LATCH;
                end
                LATCH: begin
                    shadow[v] <= active_q[v] ? rom_data : '0;
                    if (v == LAST_V) begin
                        state <= DONE;
                    end else begin
                        v     <= v + 1'b1;
                        state <= ADDR;
                    end
                end
                DONE: begin
                    for (int i = 0; i < NUM_VOICES; i++)
                        bus.samples[i*SAMPLE_W +: SAMPLE_W] <= shadow[i];
                    bus.samples_ready <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_sample_bank.sv
// Self-checking bench for voice_sample_bank against a phase/sine reference model.
module tb_voice_sample_bank;
    import piano_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    voice_sample_bank_if bus ();
    voice_sample_bank dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    int          rom_ref [1024];
    int unsigned m_phase [8];

    function automatic int sine_ref(input int k);
        real a;
        a = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
        return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
    endfunction

    // Reference: each voice either advances its phase mod 2^22 and looks up sine, or rests at 0.
    task automatic model_request(input logic [7:0] act, input logic [175:0] steps,
                                 output logic [127:0] exp_s);
        exp_s = '0;
        for (int k = 0; k < 8; k++) begin
            if (act[k]) begin
                m_phase[k] = (m_phase[k] + int'(steps[k*22 +: 22])) % (1 << 22);
                exp_s[k*16 +: 16] = 16'(rom_ref[m_phase[k] / 4096]);
            end else begin
                m_phase[k] = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_phase[k] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [175:0] one_step(input int voice, input int step);
        logic [175:0] s;
        s = '0;
        s[voice*22 +: 22] = 22'(step);
        return s;
    endfunction

    // Issues one request and waits (bounded) for the ready pulse; lat = -1 on timeout.
    task automatic do_request(input logic [7:0] act, input logic [175:0] steps, input bit scramble,
                              output int lat, output logic [127:0] s);
        bus.note_active   = act;
        bus.note_steps    = steps;
        bus.generate_next = 1'b1;
        tick();
        bus.generate_next = 1'b0;
        if (scramble) begin
            bus.note_active = 8'($urandom);
            for (int k = 0; k < 8; k++) bus.note_steps[k*22 +: 22] = 22'($urandom);
        end
        lat = -1;
        s   = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            tick();
            if (bus.samples_ready) begin
                lat = c;
                s   = bus.samples;
            end
        end
    endtask

    task automatic test_reset();
        bus.generate_next = 1'b0;
        bus.note_active   = '0;
        bus.note_steps    = '0;
        reset = 1'b1;
        tick();
        tick();
        model_reset();
        checks++;
        if (bus.samples !== '0 || bus.samples_ready !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: samples=%h ready=%b overrun=%b, required all zero",
                     bus.samples, bus.samples_ready, bus.overrun);
        end
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            checks++;
            if (bus.samples !== '0 || bus.samples_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: samples=%h ready=%b, required 0/0",
                         c, bus.samples, bus.samples_ready);
            end
        end
    endtask

    task automatic test_single_voice();
        int lat;
        logic [127:0] s, exp_s;
        model_request(8'h01, one_step(0, 4096), exp_s);
        do_request(8'h01, one_step(0, 4096), 1'b0, lat, s);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL single_latency: got %0d, required 17", lat);
        end
        checks++;
        if ($signed(s[15:0]) !== 16'sd201 || s[127:16] !== '0) begin
            errors++;
            $display("FAIL single_slots: slot0=%0d rest=%h, required 201 and zeros",
                     $signed(s[15:0]), s[127:16]);
        end
        checks++;
        if (s !== exp_s) begin
            errors++;
            $display("FAIL single_model: got %h, required %h", s, exp_s);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.samples !== exp_s || bus.samples_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_between_pulses: samples=%h ready=%b, required %h / 0",
                         bus.samples, bus.samples_ready, exp_s);
            end
        end
    endtask

    task automatic test_voice3_sweep();
        int lat;
        logic [127:0] s, exp_s;
        logic signed [15:0] want [4];
        want[0] = 16'sd32767;
        want[1] = 16'sd0;
        want[2] = -16'sd32767;
        want[3] = 16'sd0;
        for (int r = 0; r < 4; r++) begin
            model_request(8'h08, one_step(3, 1048576), exp_s);
            do_request(8'h08, one_step(3, 1048576), 1'b0, lat, s);
            checks++;
            if (lat !== 17 || $signed(s[63:48]) !== want[r] || s !== exp_s) begin
                errors++;
                $display("FAIL voice3_sweep req %0d: lat=%0d slot3=%0d bus=%h, required lat 17 slot3=%0d bus=%h",
                         r, lat, $signed(s[63:48]), s, want[r], exp_s);
            end
        end
    endtask

    task automatic test_reactivate();
        int lat;
        logic [127:0] s, exp_s;
        logic [7:0] acts [3];
        int want [3];
        acts[0] = 8'h01; acts[1] = 8'h00; acts[2] = 8'h01;
        want[0] = 201;   want[1] = 0;     want[2] = 201;
        for (int r = 0; r < 3; r++) begin
            model_request(acts[r], one_step(0, 4096), exp_s);
            do_request(acts[r], one_step(0, 4096), 1'b0, lat, s);
            checks++;
            if (int'($signed(s[15:0])) !== want[r] || s !== exp_s) begin
                errors++;
                $display("FAIL reactivate step %0d: slot0=%0d bus=%h, required %0d bus=%h",
                         r, $signed(s[15:0]), s, want[r], exp_s);
            end
        end
    endtask

    task automatic test_zero_step();
        int lat;
        logic [127:0] s, exp_s;
        model_request(8'h20, one_step(5, 1048576), exp_s);
        do_request(8'h20, one_step(5, 1048576), 1'b0, lat, s);
        model_request(8'h20, '0, exp_s);
        do_request(8'h20, '0, 1'b0, lat, s);
        checks++;
        if ($signed(s[95:80]) !== 16'sd32767 || s !== exp_s) begin
            errors++;
            $display("FAIL zero_step_hold: slot5=%0d bus=%h, required 32767 bus=%h",
                     $signed(s[95:80]), s, exp_s);
        end
    endtask

    task automatic test_overrun();
        int pulses, first;
        logic [127:0] s, exp_s;
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear_before: got %b, required 0", bus.overrun);
        end
        model_request(8'h02, one_step(1, 12345), exp_s);
        bus.note_active   = 8'h02;
        bus.note_steps    = one_step(1, 12345);
        bus.generate_next = 1'b1;
        tick();
        bus.generate_next = 1'b0;
        pulses = 0;
        first  = -1;
        s      = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            bus.generate_next = (c == 4);
            if (bus.samples_ready) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    s     = bus.samples;
                end
            end
        end
        checks++;
        if (pulses !== 1 || first !== 17) begin
            errors++;
            $display("FAIL overrun_pulses: pulses=%0d first=%0d, required 1 at 17", pulses, first);
        end
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b, required 1", bus.overrun);
        end
        checks++;
        if (s !== exp_s) begin
            errors++;
            $display("FAIL overrun_samples: got %h, required %h", s, exp_s);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int pulses, lat;
        logic [127:0] s, exp_s;
        bus.note_active   = 8'hFF;
        bus.note_steps    = {8{22'd300000}};
        bus.generate_next = 1'b1;
        tick();
        bus.generate_next = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            reset = (c == 8);
            if (bus.samples_ready) pulses++;
        end
        model_reset();
        checks++;
        if (pulses !== 0 || bus.samples !== '0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sweep: pulses=%0d samples=%h overrun=%b, required 0/0/0",
                     pulses, bus.samples, bus.overrun);
        end
        model_request(8'h01, one_step(0, 4096), exp_s);
        do_request(8'h01, one_step(0, 4096), 1'b0, lat, s);
        checks++;
        if (lat !== 17 || $signed(s[15:0]) !== 16'sd201 || s !== exp_s) begin
            errors++;
            $display("FAIL after_reset_request: lat=%0d bus=%h, required lat 17 bus=%h", lat, s, exp_s);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0]   act;
        logic [175:0] steps;
        logic [127:0] s, exp_s;
        for (int r = 0; r < 12; r++) begin
            act = 8'($urandom);
            for (int k = 0; k < 8; k++)
                steps[k*22 +: 22] = ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom);
            model_request(act, steps, exp_s);
            do_request(act, steps, 1'b1, lat, s);
            checks++;
            if (lat !== 17 || s !== exp_s) begin
                errors++;
                $display("FAIL random req %0d: lat=%0d bus=%h, required lat 17 bus=%h", r, lat, s, exp_s);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom_ref[k] = sine_ref(k);
        test_reset();
        test_single_voice();
        test_voice3_sweep();
        test_reactivate();
        test_zero_step();
        test_overrun();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
